// File: rtl/bc_uart_tx_pkg.sv
// Shared definitions for the UART transmitter: FSM encoding, frame constants and
// the pointer helper used by the 16-entry FIFO.
package bc_uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int BITS_PER_FRAME = 10;
  localparam int TICKS_PER_BIT  = 16;

  // Tick count that closes a bit, and the data-bit index that closes the byte.
  localparam logic [3:0] CNT_LAST  = 4'(TICKS_PER_BIT - 1);
  localparam logic [2:0] DATA_LAST = 3'(BITS_PER_FRAME - 3);

  function automatic logic [3:0] ptr_inc(input logic [3:0] p);
    return p + 4'd1;
  endfunction

endpackage

// File: rtl/bc_uart_tx_if.sv
// Host-side write port and status flags of the UART transmitter.
interface bc_uart_tx_if;
  logic       wr;
  logic       clear;
  logic [7:0] di;
  logic       empty;
  logic       full;
  logic       busy;
  logic       over_run;

  modport master (output wr, clear, di, input empty, full, busy, over_run);
  modport slave  (input wr, clear, di, output empty, full, busy, over_run);
endinterface

// File: rtl/bc_fifo16x8.sv
// 16x8 distributed-RAM storage: synchronous write, asynchronous read.
// Pointers and flags are owned by the instantiating block.
module bc_fifo16x8 (
  input  logic       clk,
  input  logic       wr,
  input  logic [3:0] wa,
  input  logic [3:0] ra,
  input  logic [7:0] di,
  output logic [7:0] dout
);

  logic [7:0] mem_q [16];

  // RAM write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem_q[wa] <= di;
    end
  end

  assign dout = mem_q[ra];

endmodule

// File: rtl/bc_uart_tx.sv
// UART transmitter: 8N1 frames, 16 baud16x_ce ticks per bit, fed from a 16-entry
// byte FIFO (15 usable) and streamed back-to-back while data is queued.
module bc_uart_tx
  import bc_uart_tx_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        baud16x_ce,
  bc_uart_tx_if.slave host,
  output logic        sout
);

  tx_state_e  state_q, state_d;
  logic [3:0] wa_q, wa_d;
  logic [3:0] ra_q, ra_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shifter_q, shifter_d;
  logic       sout_q, sout_d;
  logic       over_run_q, over_run_d;
  logic       empty_q, empty_d;
  logic       full_q, full_d;
  logic       busy_q, busy_d;

  logic       full_now_s;
  logic       empty_now_s;
  logic       wr_accept_s;
  logic [7:0] fifo_dout_s;

  // full is judged on the current pointers, so a same-cycle pop never frees a slot.
  assign full_now_s  = (ptr_inc(wa_q) == ra_q);
  assign empty_now_s = (wa_q == ra_q);
  assign wr_accept_s = host.wr & ~full_now_s & ~host.clear;

  bc_fifo16x8 u_fifo (
    .clk  (clk),
    .wr   (wr_accept_s),
    .wa   (wa_q),
    .ra   (ra_q),
    .di   (host.di),
    .dout (fifo_dout_s)
  );

  // Next-state logic for pointers, overrun flag and the serialiser FSM.
  always_comb begin
    state_d    = state_q;
    wa_d       = wa_q;
    ra_d       = ra_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shifter_d  = shifter_q;
    sout_d     = sout_q;
    over_run_d = over_run_q;

    if (host.clear) begin
      state_d    = IDLE;
      wa_d       = 4'd0;
      ra_d       = 4'd0;
      cnt_d      = 4'd0;
      bit_cnt_d  = 3'd0;
      sout_d     = 1'b1;
      over_run_d = 1'b0;
    end else begin
      if (wr_accept_s) begin
        wa_d = ptr_inc(wa_q);
      end else if (host.wr) begin
        over_run_d = 1'b1;
      end else begin
        over_run_d = over_run_q;
      end

      if (baud16x_ce) begin
        case (state_q)
          IDLE: begin
            if (!empty_now_s) begin
              shifter_d = fifo_dout_s;
              ra_d      = ptr_inc(ra_q);
              cnt_d     = 4'd0;
              sout_d    = 1'b0;
              state_d   = START;
            end else begin
              sout_d = 1'b1;
            end
          end
          START: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == CNT_LAST) begin
              sout_d    = shifter_q[0];
              bit_cnt_d = 3'd0;
              state_d   = DATA;
            end else begin
              state_d = START;
            end
          end
          DATA: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == CNT_LAST) begin
              shifter_d = {1'b0, shifter_q[7:1]};
              bit_cnt_d = bit_cnt_q + 3'd1;
              if (bit_cnt_q == DATA_LAST) begin
                sout_d  = 1'b1;
                state_d = STOP;
              end else begin
                sout_d = shifter_q[1];
              end
            end else begin
              state_d = DATA;
            end
          end
          STOP: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == CNT_LAST) begin
              // Chain straight into the next start bit when more data is queued.
              if (!empty_now_s) begin
                shifter_d = fifo_dout_s;
                ra_d      = ptr_inc(ra_q);
                cnt_d     = 4'd0;
                sout_d    = 1'b0;
                state_d   = START;
              end else begin
                sout_d  = 1'b1;
                state_d = IDLE;
              end
            end else begin
              state_d = STOP;
            end
          end
          default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            sout_d  = 1'b1;
          end
        endcase
      end else begin
        state_d = state_q;
      end
    end

    empty_d = (wa_d == ra_d);
    full_d  = (ptr_inc(wa_d) == ra_d);
    busy_d  = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wa_q       <= 4'd0;
      ra_q       <= 4'd0;
      cnt_q      <= 4'd0;
      bit_cnt_q  <= 3'd0;
      shifter_q  <= 8'd0;
      sout_q     <= 1'b1;
      over_run_q <= 1'b0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wa_q       <= wa_d;
      ra_q       <= ra_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shifter_q  <= shifter_d;
      sout_q     <= sout_d;
      over_run_q <= over_run_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      busy_q     <= busy_d;
    end
  end

  assign sout          = sout_q;
  assign host.empty    = empty_q;
  assign host.full     = full_q;
  assign host.busy     = busy_q;
  assign host.over_run = over_run_q;

endmodule

// File: tb/tb_bc_uart_tx.sv
// Directed bench for bc_uart_tx: frame shape and timing, bursts, full/overrun,
// pointer wrap, clear mid-frame and asynchronous reset mid-frame.
module tb_bc_uart_tx;

  logic clk;
  logic reset_n;
  logic baud16x_ce;
  logic sout;

  int   checks;
  int   errors;
  int   ce_cnt;
  bit   ce_en;

  bc_uart_tx_if u_if ();

  bc_uart_tx dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .baud16x_ce (baud16x_ce),
    .host       (u_if),
    .sout       (sout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; inputs and samples sit 1 time unit after the rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    ce_cnt     = ce_cnt + 1;
    baud16x_ce = ce_en && (ce_cnt % 4 == 0);
  endtask

  task automatic adv(input int n);
    repeat (n) cycle();
  endtask

  task automatic wr_byte(input logic [7:0] b);
    u_if.wr = 1'b1;
    u_if.di = b;
    cycle();
    u_if.wr = 1'b0;
  endtask

  task automatic find_start(input string tag);
    int n;
    n = 0;
    while (sout !== 1'b0 && n < 200) begin
      cycle();
      n++;
    end
    chk(tag, 32'(sout), 32'd0);
  endtask

  // Called at the start-bit edge (t=0); each tick is 4 clk, each bit 64 clk.
  // Returns at t=640, where the next frame must start or the line must be idle.
  task automatic expect_frame(input string tag, input logic [7:0] b, input bit more);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    chk({tag, "_start"}, 32'(sout), 32'd0);
    chk({tag, "_busy0"}, 32'(u_if.busy), 32'd1);
    adv(32);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("%s_bit%0d", tag, k), 32'(sout), 32'(bits[k]));
      if (k < 9) adv(64);
    end
    adv(31);
    chk({tag, "_stop_end"}, 32'(sout), 32'd1);
    chk({tag, "_busy_end"}, 32'(u_if.busy), 32'd1);
    adv(1);
    chk({tag, "_after"}, 32'(sout), more ? 32'd0 : 32'd1);
    chk({tag, "_busy_after"}, 32'(u_if.busy), more ? 32'd1 : 32'd0);
  endtask

  initial begin
    int lows;
    int idx;
    int bursts [3];
    logic [7:0] v;

    checks = 0;
    errors = 0;
    ce_cnt = 0;
    ce_en  = 1'b0;
    baud16x_ce = 1'b0;
    u_if.wr = 1'b0;
    u_if.clear = 1'b0;
    u_if.di = 8'h00;
    reset_n = 1'b0;

    // Reset state
    #12;
    chk("rst_sout", 32'(sout), 32'd1);
    chk("rst_empty", 32'(u_if.empty), 32'd1);
    chk("rst_full", 32'(u_if.full), 32'd0);
    chk("rst_busy", 32'(u_if.busy), 32'd0);
    chk("rst_over_run", 32'(u_if.over_run), 32'd0);
    cycle();
    reset_n = 1'b1;
    cycle();

    // 1: single byte A5, no ticks while writing
    wr_byte(8'hA5);
    chk("t1_empty_after_wr", 32'(u_if.empty), 32'd0);
    chk("t1_busy_no_tick", 32'(u_if.busy), 32'd0);
    adv(3);
    chk("t1_sout_no_tick", 32'(sout), 32'd1);
    ce_en = 1'b1;
    find_start("t1_find");
    chk("t1_empty_after_load", 32'(u_if.empty), 32'd1);
    expect_frame("t1", 8'hA5, 1'b0);

    // 2: burst of three contiguous frames
    wr_byte(8'h00);
    wr_byte(8'hFF);
    wr_byte(8'h55);
    find_start("t2_find");
    expect_frame("t2a", 8'h00, 1'b1);
    expect_frame("t2b", 8'hFF, 1'b1);
    expect_frame("t2c", 8'h55, 1'b0);

    // 3: full and overrun with ticks stopped
    ce_en = 1'b0;
    baud16x_ce = 1'b0;
    cycle();
    for (int i = 0; i < 16; i++) begin
      v = 8'(i * 17) ^ 8'h5A;
      wr_byte(v);
      if (i == 13) chk("t3_not_full_14", 32'(u_if.full), 32'd0);
      if (i == 14) chk("t3_full_15", 32'(u_if.full), 32'd1);
      if (i == 14) chk("t3_no_ovr_15", 32'(u_if.over_run), 32'd0);
    end
    chk("t3_full_16", 32'(u_if.full), 32'd1);
    chk("t3_over_run", 32'(u_if.over_run), 32'd1);
    ce_en = 1'b1;
    find_start("t3_find");
    chk("t3_full_after_pop", 32'(u_if.full), 32'd0);
    for (int i = 0; i < 15; i++) begin
      v = 8'(i * 17) ^ 8'h5A;
      expect_frame($sformatf("t3f%0d", i), v, i < 14);
    end
    chk("t3_empty_end", 32'(u_if.empty), 32'd1);

    // 4: 40 bytes in bursts across the pointer wrap
    bursts[0] = 15;
    bursts[1] = 10;
    bursts[2] = 15;
    idx = 0;
    for (int b = 0; b < 3; b++) begin
      ce_en = 1'b0;
      baud16x_ce = 1'b0;
      cycle();
      for (int i = 0; i < bursts[b]; i++) wr_byte(8'(40 + (idx + i) * 7));
      chk($sformatf("t4_full_b%0d", b), 32'(u_if.full), bursts[b] == 15 ? 32'd1 : 32'd0);
      chk($sformatf("t4_empty_b%0d", b), 32'(u_if.empty), 32'd0);
      ce_en = 1'b1;
      find_start($sformatf("t4_find_b%0d", b));
      for (int i = 0; i < bursts[b]; i++) begin
        expect_frame($sformatf("t4_%0d", idx), 8'(40 + idx * 7), i < bursts[b] - 1);
        idx++;
      end
      chk($sformatf("t4_empty_end_b%0d", b), 32'(u_if.empty), 32'd1);
    end
    chk("t4_over_run_sticky", 32'(u_if.over_run), 32'd1);

    // 5: clear during data bit 3 with a same-cycle write
    wr_byte(8'h3C);
    wr_byte(8'h99);
    find_start("t5_find");
    adv(288);
    chk("t5_busy_before", 32'(u_if.busy), 32'd1);
    u_if.clear = 1'b1;
    u_if.wr = 1'b1;
    u_if.di = 8'h77;
    cycle();
    u_if.clear = 1'b0;
    u_if.wr = 1'b0;
    chk("t5_sout", 32'(sout), 32'd1);
    chk("t5_empty", 32'(u_if.empty), 32'd1);
    chk("t5_busy", 32'(u_if.busy), 32'd0);
    chk("t5_over_run", 32'(u_if.over_run), 32'd0);
    lows = 0;
    for (int i = 0; i < 800; i++) begin
      cycle();
      if (sout !== 1'b1) lows++;
    end
    chk("t5_line_quiet", 32'(lows), 32'd0);
    chk("t5_empty_later", 32'(u_if.empty), 32'd1);

    // 6: asynchronous reset mid-frame, then normal transmission
    wr_byte(8'hE7);
    wr_byte(8'h18);
    find_start("t6_find");
    adv(100);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_sout", 32'(sout), 32'd1);
    chk("t6_empty", 32'(u_if.empty), 32'd1);
    chk("t6_busy", 32'(u_if.busy), 32'd0);
    cycle();
    reset_n = 1'b1;
    cycle();
    wr_byte(8'hC3);
    find_start("t6_find2");
    expect_frame("t6", 8'hC3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
